// File: rtl/seq_divider.sv
// Signed restoring divider: one quotient bit per clock, fixed WIDTH+1 cycle latency.
// out = {remainder, quotient}; divide-by-zero yields q = all ones, r = a, div0 = 1.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_a,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic               done,
  output logic               div0
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] amag, bmag, rem, quo;
  logic             sa, sb, bz;

  logic [WIDTH:0]   sh, diff;
  logic             ge;
  logic [WIDTH-1:0] qfix, rfix;

  // Shifted partial remainder is WIDTH+1 bits so |b| = 2^(WIDTH-1) cannot overflow.
  assign sh   = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, bmag};
  assign ge   = sh >= {1'b0, bmag};

  always_comb begin
    qfix = (sa ^ sb) ? -quo : quo;
    rfix = sa ? -rem : rem;
    if (bz) begin
      qfix = '1;
      rfix = sa ? -amag : amag;
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state <= IDLE;
      cnt   <= '0;
      amag  <= '0;
      bmag  <= '0;
      rem   <= '0;
      quo   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      bz    <= 1'b0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            amag  <= a[WIDTH-1] ? -a : a;
            bmag  <= b[WIDTH-1] ? -b : b;
            quo   <= a[WIDTH-1] ? -a : a;
            sa    <= a[WIDTH-1];
            sb    <= b[WIDTH-1];
            bz    <= (b == '0);
            rem   <= '0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          rem <= ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          out   <= {rfix, qfix};
          div0  <= bz;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotient/remainder vectors,
// latency, busy-load rejection, back-to-back load and mid-run reset.
module tb_seq_divider;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_a;
  logic           load;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] out;
  logic           busy, done, div0;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] prev_out = '0;
  logic           prev_div0 = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_a(rst_a), .load(load), .a(a), .b(b),
    .out(out), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load at the next rising edge (edge k); returns #1 after it.
  task automatic start(input logic [W-1:0] ia, input logic [W-1:0] ib, input string tag);
    @(negedge clk);
    a = ia; b = ib; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk({tag, ".busy_on"}, 64'(busy), 64'd1);
    chk({tag, ".done_lo"}, 64'(done), 64'd0);
  endtask

  // Wait n edges, confirm nothing finished early and out held, then expect done.
  task automatic finish(input int n, input logic [2*W-1:0] exp, input logic ediv0, input string tag);
    repeat (n) @(posedge clk);
    #1;
    chk({tag, ".early_done"}, 64'(done), 64'd0);
    chk({tag, ".out_hold"}, out, prev_out);
    chk({tag, ".div0_hold"}, 64'(div0), 64'(prev_div0));
    @(posedge clk); #1;
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy_off"}, 64'(busy), 64'd0);
    chk({tag, ".out"}, out, exp);
    chk({tag, ".div0"}, 64'(div0), 64'(ediv0));
    prev_out  = exp;
    prev_div0 = ediv0;
  endtask

  initial begin
    rst_a = 1'b0; load = 1'b0; a = '0; b = '0;
    #1;
    chk("rst.out", out, '0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.div0", 64'(div0), 64'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;

    start(32'd10, 32'd2, "d10_2");
    finish(32, 64'h0000_0000_0000_0005, 1'b0, "d10_2");
    @(posedge clk); #1;
    chk("done_pulse_width", 64'(done), 64'd0);

    start(-32'sd7, 32'd2, "dm7_2");
    finish(32, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, "dm7_2");
    start(32'd7, -32'sd2, "d7_m2");
    finish(32, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0, "d7_m2");
    start(-32'sd100, 32'd7, "dm100_7");
    finish(32, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0, "dm100_7");
    start(32'd7, 32'd0, "d7_0");
    finish(32, {32'h0000_0007, 32'hFFFF_FFFF}, 1'b1, "d7_0");
    start(-32'sd5, 32'd0, "dm5_0");
    finish(32, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1, "dm5_0");
    start(32'h8000_0000, 32'hFFFF_FFFF, "dmin_m1");
    finish(32, {32'h0, 32'h8000_0000}, 1'b0, "dmin_m1");
    start(32'h8000_0000, 32'h8000_0000, "dmin_min");
    finish(32, {32'h0, 32'h1}, 1'b0, "dmin_min");
    start(32'h7FFF_FFFF, 32'h8000_0000, "dmax_min");
    finish(32, {32'h7FFF_FFFF, 32'h0}, 1'b0, "dmax_min");

    // Ignored load while busy, operand changes mid-run, then back-to-back load.
    start(32'd14, 32'd5, "d14_5");
    repeat (9) @(posedge clk);
    @(negedge clk);
    a = 32'd15; b = 32'd9; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("d14_5.busy_ignore", 64'(busy), 64'd1);
    a = 32'hDEAD_BEEF; b = 32'd0;
    finish(22, {32'd4, 32'd2}, 1'b0, "d14_5");
    start(32'd15, 32'd9, "d15_9");
    finish(32, {32'd6, 32'd1}, 1'b0, "d15_9");

    // Reset 20 cycles into a division aborts it.
    start(32'd1000, 32'd3, "abort");
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("abort.out", out, '0);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.div0", 64'(div0), 64'd0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("abort.no_done", 64'(done), 64'd0);
    end
    prev_out = '0; prev_div0 = 1'b0;
    @(negedge clk);
    rst_a = 1'b1; a = 32'd20; b = 32'd3; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("post_rst.busy_on", 64'(busy), 64'd1);
    finish(32, {32'd2, 32'd6}, 1'b0, "d20_3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32, operand width; out is 2*WIDTH bits.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_a  input  1  asynchronous active-low reset; low clears all state immediately, independent of clk.
REQ-004 load  input  1  start request; sampled on rising clk edge, accepted only in IDLE.
REQ-005 a  input  WIDTH  dividend, two's complement signed.
REQ-006 b  input  WIDTH  divisor, two's complement signed.
REQ-007 out  output  2*WIDTH  result: out[2W-1:W] = remainder, out[W-1:0] = quotient; registered.
REQ-008 busy  output  1  high while a division is in progress (CALC or FIX).
REQ-009 done  output  1  one-cycle pulse marking out valid with a new result.
REQ-010 div0  output  1  registered with out; high when the result came from a zero divisor.

Function
REQ-011 States SHALL be IDLE, CALC, FIX; no other states are reachable.
REQ-012 IDLE with load=1 at edge k: capture |a|, |b|, sign(a), sign(b), b==0; clear partial remainder; iteration counter = WIDTH; go to CALC; busy=1 after edge k.
REQ-013 CALC: one restoring-division step per edge (shift {rem,quo} left 1, trial-subtract |b|, keep when non-negative, set quotient LSB); exactly WIDTH steps, edges k+1..k+WIDTH.
REQ-014 Trial subtraction SHALL use WIDTH+1 bits so |b| = 2^(WIDTH-1) and |a| = 2^(WIDTH-1) are handled without overflow.
REQ-015 FIX, edge k+WIDTH+1: apply signs; write out, div0; done=1, busy=0; go to IDLE.
REQ-016 Latency SHALL be fixed at WIDTH+1 cycles from load edge to done for every operand pair, including divide-by-zero.
REQ-017 Quotient truncates toward zero; quotient negated when sign(a) XOR sign(b); remainder takes sign of a; a = q*b + r always holds when b != 0.
REQ-018 b == 0: quotient = all ones, remainder = a (unmodified), div0 = 1.
REQ-019 a = -2^(WIDTH-1), b = -1: quotient = -2^(WIDTH-1) (wraps), remainder = 0, div0 = 0.
REQ-020 load while busy=1 SHALL be ignored; a and b changes during CALC/FIX SHALL not affect the result.
REQ-021 done SHALL deassert at the edge after it rises; load at that edge is accepted (back-to-back throughput WIDTH+2 cycles).
REQ-022 out and div0 SHALL hold their last value until the next FIX; they do not change during CALC.

Reset
REQ-023 rst_a low SHALL force state IDLE, out = 0, busy = 0, done = 0, div0 = 0, counter and internal registers 0.
REQ-024 Reset asserted mid-operation SHALL abort the division with no done pulse; after release the block waits in IDLE for load.
REQ-025 load high during the first edge after rst_a release SHALL be accepted normally.

Verification
REQ-026 a=10, b=2, load one cycle -> after 33 cycles done=1, out=64'h0000_0000_0000_0005, div0=0.
REQ-027 a=-7, b=2 -> out={32'hFFFF_FFFF, 32'hFFFF_FFFD} (q=-3, r=-1); a=7, b=-2 -> q=-3, r=1.
REQ-028 a=7, b=0 -> out={32'h0000_0007, 32'hFFFF_FFFF}, div0=1, latency 33 cycles.
REQ-029 a=32'h8000_0000, b=32'hFFFF_FFFF -> out={32'h0, 32'h8000_0000}, div0=0; a=32'h8000_0000, b=32'h8000_0000 -> q=1, r=0.
REQ-030 Start 14/5, pulse load with 15/9 at cycle 10, change a/b mid-run -> single done, out q=2 r=4; second load at done edge -> q=1, r=6 after 33 more cycles.
REQ-031 Assert rst_a low at cycle 20 of a division -> out=0, busy=0, done never pulses; release, load 20/3 -> q=6, r=2.
